// File: rtl/mem_2r1w_req_sched.sv
// Request scheduler for a 2-read/1-write bit-masked memory: core owns port A (read/write),
// snoop owns read-only port B, with a fair priority bit and a per-client response buffer.

module mem_2r1w_req_sched_resp #(
    parameter int width_p = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_grant,
    input  logic               yumi,
    input  logic [width_p-1:0] mem_data,
    output logic               valid,
    output logic [width_p-1:0] data,
    output logic               free
);

    typedef enum logic [1:0] {EMPTY, FRESH, HELD} resp_state_e;

    resp_state_e        state, state_n;
    logic [width_p-1:0] hold;

    // The memory only presents read data for one cycle, so an unconsumed FRESH response is parked in hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            hold  <= '0;
        end else begin
            state <= state_n;
            if (state == FRESH && !yumi) hold <= mem_data;
        end
    end

    // Kept apart from the next-state logic: the grant that feeds state_n itself depends on free
    assign free = (state == EMPTY) | yumi;

    always_comb begin
        valid = 1'b0;
        data  = '0;
        case (state)
            FRESH: begin
                valid = 1'b1;
                data  = mem_data;
            end
            HELD: begin
                valid = 1'b1;
                data  = hold;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            EMPTY: if (read_grant) state_n = FRESH;
            FRESH: state_n = yumi ? (read_grant ? FRESH : EMPTY) : HELD;
            HELD:  if (yumi) state_n = read_grant ? FRESH : EMPTY;
            default: state_n = EMPTY;
        endcase
    end

endmodule

module mem_2r1w_req_sched #(
    parameter  int width_p       = 32,
    parameter  int els_p         = 64,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     core_v_i,
    input  logic                     core_w_i,
    input  logic [addr_width_lp-1:0] core_addr_i,
    input  logic [width_p-1:0]       core_w_mask_i,
    input  logic [width_p-1:0]       core_data_i,
    output logic                     core_ready_o,
    output logic                     core_v_o,
    output logic [width_p-1:0]       core_data_o,
    input  logic                     core_yumi_i,
    input  logic                     snp_v_i,
    input  logic [addr_width_lp-1:0] snp_addr_i,
    output logic                     snp_ready_o,
    output logic                     snp_v_o,
    output logic [width_p-1:0]       snp_data_o,
    input  logic                     snp_yumi_i,
    output logic                     mem_a_v_o,
    output logic                     mem_a_w_o,
    output logic [addr_width_lp-1:0] mem_a_addr_o,
    output logic [width_p-1:0]       mem_a_w_mask_o,
    output logic [width_p-1:0]       mem_a_data_o,
    input  logic [width_p-1:0]       mem_a_data_i,
    output logic                     mem_b_v_o,
    output logic [addr_width_lp-1:0] mem_b_addr_o,
    input  logic [width_p-1:0]       mem_b_data_i
);

    logic core_free, snp_free;
    logic conflict, prio_snp;
    logic core_grant, snp_grant;

    assign conflict = core_v_i & core_w_i & snp_v_i & snp_free;

    // A core write and a snoop read may never share a cycle; the priority holder wins and the bit passes to the loser
    always_comb begin
        core_grant = 1'b0;
        snp_grant  = 1'b0;
        if (!reset_i) begin
            if (conflict) begin
                core_grant = ~prio_snp;
                snp_grant  = prio_snp;
            end else begin
                core_grant = core_v_i & (core_w_i | core_free);
                snp_grant  = snp_v_i & snp_free;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) prio_snp <= 1'b0;
        else if (conflict) prio_snp <= ~prio_snp;
    end

    assign core_ready_o   = core_grant;
    assign snp_ready_o    = snp_grant;
    assign mem_a_v_o      = core_grant;
    assign mem_a_w_o      = core_grant & core_w_i;
    assign mem_a_addr_o   = core_grant ? core_addr_i : '0;
    assign mem_a_w_mask_o = mem_a_w_o ? core_w_mask_i : '0;
    assign mem_a_data_o   = mem_a_w_o ? core_data_i : '0;
    assign mem_b_v_o      = snp_grant;
    assign mem_b_addr_o   = snp_grant ? snp_addr_i : '0;

    mem_2r1w_req_sched_resp #(.width_p(width_p)) core_resp (
        .clk        (clk_i),
        .rst        (reset_i),
        .read_grant (core_grant & ~core_w_i),
        .yumi       (core_yumi_i),
        .mem_data   (mem_a_data_i),
        .valid      (core_v_o),
        .data       (core_data_o),
        .free       (core_free)
    );

    mem_2r1w_req_sched_resp #(.width_p(width_p)) snp_resp (
        .clk        (clk_i),
        .rst        (reset_i),
        .read_grant (snp_grant),
        .yumi       (snp_yumi_i),
        .mem_data   (mem_b_data_i),
        .valid      (snp_v_o),
        .data       (snp_data_o),
        .free       (snp_free)
    );

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(core_yumi_i && !core_v_o));
            assert (!(snp_yumi_i && !snp_v_o));
            assert (!(mem_b_v_o && mem_a_v_o && mem_a_w_o));
        end
    end

endmodule

// File: tb/tb_mem_2r1w_req_sched.sv
// Directed bench for mem_2r1w_req_sched: a behavioural 2r1w masked memory plus a vector table
// and hand-written sequences for back-to-back reads and mid-flight reset.

module tb_mem_2r1w_req_sched;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        core_v_i, core_w_i, core_yumi_i;
    logic [5:0]  core_addr_i;
    logic [31:0] core_w_mask_i, core_data_i;
    logic        core_ready_o, core_v_o;
    logic [31:0] core_data_o;
    logic        snp_v_i, snp_yumi_i;
    logic [5:0]  snp_addr_i;
    logic        snp_ready_o, snp_v_o;
    logic [31:0] snp_data_o;
    logic        mem_a_v_o, mem_a_w_o, mem_b_v_o;
    logic [5:0]  mem_a_addr_o, mem_b_addr_o;
    logic [31:0] mem_a_w_mask_o, mem_a_data_o;
    logic [31:0] mem_a_data_i = '0;
    logic [31:0] mem_b_data_i = '0;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    mem_2r1w_req_sched #(.width_p(32), .els_p(64)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .core_v_i(core_v_i), .core_w_i(core_w_i), .core_addr_i(core_addr_i),
        .core_w_mask_i(core_w_mask_i), .core_data_i(core_data_i),
        .core_ready_o(core_ready_o), .core_v_o(core_v_o), .core_data_o(core_data_o),
        .core_yumi_i(core_yumi_i),
        .snp_v_i(snp_v_i), .snp_addr_i(snp_addr_i), .snp_ready_o(snp_ready_o),
        .snp_v_o(snp_v_o), .snp_data_o(snp_data_o), .snp_yumi_i(snp_yumi_i),
        .mem_a_v_o(mem_a_v_o), .mem_a_w_o(mem_a_w_o), .mem_a_addr_o(mem_a_addr_o),
        .mem_a_w_mask_o(mem_a_w_mask_o), .mem_a_data_o(mem_a_data_o), .mem_a_data_i(mem_a_data_i),
        .mem_b_v_o(mem_b_v_o), .mem_b_addr_o(mem_b_addr_o), .mem_b_data_i(mem_b_data_i)
    );

    function automatic logic [31:0] init_val(input logic [5:0] a);
        case (a)
            6'd3:    return 32'h1234_5678;
            6'd5:    return 32'hA5A5_A5A5;
            default: return 32'hC0DE_0000 | {26'd0, a};
        endcase
    endfunction

    // Memory contents after the writes this bench performs
    function automatic logic [31:0] exp_data(input int a);
        case (a)
            3:       return 32'h12FF_0078;
            10:      return 32'h0000_00AA;
            20:      return 32'hDEAD_BEEF;
            default: return init_val(6'(a));
        endcase
    endfunction

    // Unwritten words read back their init value, which avoids a separate fill pass
    bit [31:0] mem [64];
    bit [63:0] written;

    function automatic logic [31:0] rd_val(input logic [5:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_a_v_o && mem_a_w_o) begin
            mem[mem_a_addr_o]     <= (rd_val(mem_a_addr_o) & ~mem_a_w_mask_o) | (mem_a_data_o & mem_a_w_mask_o);
            written[mem_a_addr_o] <= 1'b1;
        end
        if (mem_a_v_o && !mem_a_w_o) mem_a_data_i <= rd_val(mem_a_addr_o);
        if (mem_b_v_o) mem_b_data_i <= rd_val(mem_b_addr_o);
    end

    always @(negedge clk) begin
        if (mem_b_v_o && mem_a_v_o && mem_a_w_o) overlap_cnt++;
    end

    typedef struct {
        logic        cv, cw;
        logic [5:0]  ca;
        logic [31:0] cm, cd;
        logic        cy;
        logic        sv;
        logic [5:0]  sa;
        logic        sy;
        logic        e_cr, e_sr, e_cvo;
        logic [31:0] e_cd;
        logic        e_svo;
        logic [31:0] e_sd;
    } vec_t;

    function automatic vec_t mk(input logic cv, input logic cw, input logic [5:0] ca,
                                input logic [31:0] cm, input logic [31:0] cd, input logic cy,
                                input logic sv, input logic [5:0] sa, input logic sy,
                                input logic e_cr, input logic e_sr, input logic e_cvo,
                                input logic [31:0] e_cd, input logic e_svo, input logic [31:0] e_sd);
        vec_t t;
        t.cv = cv; t.cw = cw; t.ca = ca; t.cm = cm; t.cd = cd; t.cy = cy;
        t.sv = sv; t.sa = sa; t.sy = sy;
        t.e_cr = e_cr; t.e_sr = e_sr; t.e_cvo = e_cvo; t.e_cd = e_cd;
        t.e_svo = e_svo; t.e_sd = e_sd;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after the falling edge, then samples everything mid-cycle
    task automatic applyStimulus(input string tag, input vec_t t);
        @(negedge clk);
        core_v_i = t.cv; core_w_i = t.cw; core_addr_i = t.ca;
        core_w_mask_i = t.cm; core_data_i = t.cd; core_yumi_i = t.cy;
        snp_v_i = t.sv; snp_addr_i = t.sa; snp_yumi_i = t.sy;
        #1;
        checkOutput({tag, " core_ready"}, 32'(core_ready_o), 32'(t.e_cr));
        checkOutput({tag, " snp_ready"},  32'(snp_ready_o),  32'(t.e_sr));
        checkOutput({tag, " mem_a_v"},    32'(mem_a_v_o),    32'(t.e_cr));
        checkOutput({tag, " mem_b_v"},    32'(mem_b_v_o),    32'(t.e_sr));
        checkOutput({tag, " core_v"},     32'(core_v_o),     32'(t.e_cvo));
        checkOutput({tag, " core_data"},  core_data_o,       t.e_cd);
        checkOutput({tag, " snp_v"},      32'(snp_v_o),      32'(t.e_svo));
        checkOutput({tag, " snp_data"},   snp_data_o,        t.e_sd);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " core_ready"}, 32'(core_ready_o), 0);
        checkOutput({tag, " snp_ready"},  32'(snp_ready_o),  0);
        checkOutput({tag, " mem_a_v"},    32'(mem_a_v_o),    0);
        checkOutput({tag, " mem_b_v"},    32'(mem_b_v_o),    0);
        checkOutput({tag, " core_v"},     32'(core_v_o),     0);
        checkOutput({tag, " snp_v"},      32'(snp_v_o),      0);
        checkOutput({tag, " core_data"},  core_data_o,       0);
        checkOutput({tag, " snp_data"},   snp_data_o,        0);
    endtask

    localparam logic [31:0] M = 32'hFFFF_FFFF;
    vec_t vecs[$];
    vec_t idle;

    initial begin
        idle = mk(0,0,6'd0,0,0,0, 0,6'd0,0, 0,0,0,0,0,0);

        vecs.push_back(idle);
        vecs.push_back(mk(1,0,6'd5,0,0,0,                   0,6'd0,0,  1,0,0,0,0,0));
        vecs.push_back(mk(0,0,6'd0,0,0,1,                   0,6'd0,0,  0,0,1,32'hA5A5_A5A5,0,0));
        vecs.push_back(idle);
        vecs.push_back(mk(1,1,6'd3,32'h00FF_FF00,32'hFFFF_0000,0, 0,6'd0,0, 1,0,0,0,0,0));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   1,6'd3,0,  0,1,0,0,0,0));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   0,6'd0,1,  0,0,0,0,1,32'h12FF_0078));
        vecs.push_back(idle);
        vecs.push_back(mk(1,1,6'd10,M,32'hAA,0,             1,6'd11,0, 1,0,0,0,0,0));
        vecs.push_back(mk(1,1,6'd10,M,32'hAA,0,             1,6'd11,0, 0,1,0,0,0,0));
        vecs.push_back(mk(1,1,6'd10,M,32'hAA,0,             1,6'd11,1, 1,0,0,0,1,32'hC0DE_000B));
        vecs.push_back(mk(1,1,6'd10,M,32'hAA,0,             1,6'd11,0, 0,1,0,0,0,0));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   0,6'd0,1,  0,0,0,0,1,32'hC0DE_000B));
        vecs.push_back(idle);
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   1,6'd20,0, 0,1,0,0,0,0));
        vecs.push_back(mk(1,1,6'd20,M,32'hDEAD_BEEF,0,      1,6'd21,0, 1,0,0,0,1,32'hC0DE_0014));
        vecs.push_back(mk(1,1,6'd20,M,32'hDEAD_BEEF,0,      1,6'd21,0, 1,0,0,0,1,32'hC0DE_0014));
        vecs.push_back(mk(1,1,6'd20,M,32'hDEAD_BEEF,0,      1,6'd21,0, 1,0,0,0,1,32'hC0DE_0014));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   1,6'd21,1, 0,1,0,0,1,32'hC0DE_0014));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   0,6'd0,1,  0,0,0,0,1,32'hC0DE_0015));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   1,6'd20,0, 0,1,0,0,0,0));
        vecs.push_back(mk(0,0,6'd0,0,0,0,                   0,6'd0,1,  0,0,0,0,1,32'hDEAD_BEEF));
        vecs.push_back(idle);

        // Requests held valid during reset must still see ready low
        reset_i = 1'b1;
        core_v_i = 1'b1; core_w_i = 1'b0; core_addr_i = '0; core_w_mask_i = '0; core_data_i = '0;
        core_yumi_i = 1'b0; snp_v_i = 1'b1; snp_addr_i = '0; snp_yumi_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        core_v_i = 1'b0; snp_v_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;

        foreach (vecs[i]) applyStimulus($sformatf("row%0d", i), vecs[i]);

        for (int k = 0; k <= 9; k++) begin
            applyStimulus($sformatf("b2b%0d", k),
                mk(k < 8, 0, 6'(k), 0, 0, k >= 1 && k <= 8, 0, 6'd0, 0,
                   k < 8, 0, k >= 1 && k <= 8, (k >= 1 && k <= 8) ? exp_data(k - 1) : 32'h0, 0, 0));
        end

        applyStimulus("rstA", mk(1,0,6'd1,0,0,0, 0,6'd0,0, 1,0,0,0,0,0));
        applyStimulus("rstB", mk(0,0,6'd0,0,0,0, 1,6'd2,0, 0,1,1,exp_data(1),0,0));
        applyStimulus("rstC", mk(1,0,6'd4,0,0,0, 1,6'd6,0, 0,0,1,exp_data(1),1,exp_data(2)));
        #2 reset_i = 1'b1;
        #1;
        checkAllZero("midreset");
        core_v_i = 1'b0; snp_v_i = 1'b0;
        @(negedge clk);
        #1;
        checkAllZero("heldreset");
        reset_i = 1'b0;
        applyStimulus("postD", mk(1,0,6'd7,0,0,0, 1,6'd6,0, 1,1,0,0,0,0));
        applyStimulus("postE", mk(0,0,6'd0,0,0,1, 0,6'd0,1, 0,0,1,exp_data(7),1,exp_data(6)));
        applyStimulus("postF", idle);

        checkOutput("b_with_a_write", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
